// File: rtl/dsiq_sample_reader.sv
// Downstream I/Q sample reader: pops one 36-bit word per DAC strobe from a showahead FIFO and unpacks signed I/Q.
// Latency: pop in the strobe cycle, sample registered one cycle later. Backpressure: fifo_tready is combinational.
// Start-up and underrun recovery are gated on the FIFO fill reaching PREFILL.
module dsiq_sample_reader #(
    parameter logic [10:0] PREFILL       = 11'd256,
    parameter bit          DRAIN_ON_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] fifo_tdata,
    input  logic        fifo_tvalid,
    output logic        fifo_tready,
    input  logic [10:0] fifo_tlength,
    input  logic        tx_enable,
    input  logic        sample_strobe,
    output logic [15:0] i_out,
    output logic [15:0] q_out,
    output logic        out_valid,
    output logic        frame_last,
    output logic [15:0] underrun_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREFILL  = 2'd1,
        S_RUN      = 2'd2,
        S_UNDERRUN = 2'd3
    } state_t;

    state_t cur_state;

    logic        fill_ok;
    logic        run_pop;
    logic        run_underrun;
    logic [15:0] head_i;
    logic [15:0] head_q;
    logic        head_last;
    logic [2:0]  lane_flags_unused;

    // Lane n occupies bits [9n+8:9n] as {flag, byte}; lane0 is the first byte received.
    assign head_i            = {fifo_tdata[7:0],   fifo_tdata[16:9]};
    assign head_q            = {fifo_tdata[25:18], fifo_tdata[34:27]};
    assign head_last         = fifo_tdata[35];
    assign lane_flags_unused = {fifo_tdata[26], fifo_tdata[17], fifo_tdata[8]};

    assign fill_ok      = (fifo_tlength >= PREFILL);
    assign run_pop      = (cur_state == S_RUN) && tx_enable && sample_strobe && fifo_tvalid;
    assign run_underrun = (cur_state == S_RUN) && tx_enable && sample_strobe && !fifo_tvalid;
    assign state        = cur_state;

    always_comb begin
        fifo_tready = 1'b0;
        if (!rst) begin
            if (cur_state == S_IDLE && DRAIN_ON_IDLE)
                fifo_tready = fifo_tvalid;
            else
                fifo_tready = run_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state      <= S_IDLE;
            i_out          <= 16'd0;
            q_out          <= 16'd0;
            out_valid      <= 1'b0;
            frame_last     <= 1'b0;
            underrun_count <= 16'd0;
        end else begin
            out_valid <= sample_strobe;
            // Every strobe yields a sample; anything other than a real pop emits silence.
            if (sample_strobe) begin
                i_out      <= run_pop ? head_i : 16'd0;
                q_out      <= run_pop ? head_q : 16'd0;
                frame_last <= run_pop & head_last;
            end

            if (run_underrun && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;

            if (!tx_enable) begin
                cur_state <= S_IDLE;
            end else begin
                case (cur_state)
                    S_IDLE:     cur_state <= S_PREFILL;
                    S_PREFILL:  if (fill_ok) cur_state <= S_RUN;
                    S_RUN:      if (run_underrun) cur_state <= S_UNDERRUN;
                    S_UNDERRUN: if (fill_ok) cur_state <= S_RUN;
                    default:    cur_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsiq_sample_reader.sv
// Bench for dsiq_sample_reader: queue-backed showahead FIFO, spec-level model and per-cycle compare.
module tb_dsiq_sample_reader;

    localparam int M_IDLE = 0, M_PREFILL = 1, M_RUN = 2, M_UNDERRUN = 3;
    localparam int FILL_LEVEL = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] fifo_tdata;
    logic        fifo_tvalid;
    logic        fifo_tready;
    logic [10:0] fifo_tlength;
    logic        tx_enable;
    logic        sample_strobe;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        out_valid;
    logic        frame_last;
    logic [15:0] underrun_count;
    logic [1:0]  state;

    dsiq_sample_reader #(.PREFILL(11'd256), .DRAIN_ON_IDLE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .fifo_tdata(fifo_tdata), .fifo_tvalid(fifo_tvalid), .fifo_tready(fifo_tready),
        .fifo_tlength(fifo_tlength), .tx_enable(tx_enable), .sample_strobe(sample_strobe),
        .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .frame_last(frame_last),
        .underrun_count(underrun_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        last;
    } smp_t;

    smp_t fq[$];

    int n_chk = 0;
    int n_fail = 0;
    int pops = 0;
    int ov_cnt = 0;
    bit chk_en = 1'b0;

    // Model state and the outputs it predicts for the current cycle.
    int          m_state = M_IDLE;
    int          m_cnt = 0;
    logic [1:0]  exp_state = 2'd0;
    logic        exp_ov = 1'b0;
    logic [15:0] exp_i = 16'd0;
    logic [15:0] exp_q = 16'd0;
    logic        exp_fl = 1'b0;
    logic [15:0] exp_cnt = 16'd0;
    logic        exp_tready = 1'b0;

    int          n_state;
    logic        n_ov;
    logic [15:0] n_i;
    logic [15:0] n_q;
    logic        n_fl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] lanes(input smp_t s);
        return {s.last, s.q[7:0], 1'b0, s.q[15:8], 1'b0, s.i[7:0], 1'b0, s.i[15:8]};
    endfunction

    task automatic refresh();
        fifo_tvalid = (fq.size() > 0);
        fifo_tdata  = (fq.size() > 0) ? lanes(fq[0]) : 36'd0;
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] q, input logic last);
        smp_t s;
        s.i = i; s.q = q; s.last = last;
        fq.push_back(s);
        refresh();
    endtask

    task automatic model_eval();
        bit have, sample, starve;
        have = (fq.size() > 0);
        if (rst) begin
            exp_tready = 1'b0;
            n_state = M_IDLE; n_ov = 1'b0; n_i = 16'd0; n_q = 16'd0; n_fl = 1'b0;
            m_cnt = 0;
        end else begin
            sample = (m_state == M_RUN) && tx_enable && sample_strobe && have;
            starve = (m_state == M_RUN) && tx_enable && sample_strobe && !have;
            exp_tready = (m_state == M_IDLE) ? have : sample;
            n_ov = sample_strobe;
            n_i = exp_i; n_q = exp_q; n_fl = exp_fl;
            if (sample_strobe) begin
                n_i  = sample ? fq[0].i : 16'd0;
                n_q  = sample ? fq[0].q : 16'd0;
                n_fl = sample ? fq[0].last : 1'b0;
            end
            if (starve && m_cnt < 65535) m_cnt = m_cnt + 1;
            n_state = m_state;
            if (!tx_enable) n_state = M_IDLE;
            else if (m_state == M_IDLE) n_state = M_PREFILL;
            else if (m_state == M_RUN) n_state = starve ? M_UNDERRUN : M_RUN;
            else if (int'(fifo_tlength) >= FILL_LEVEL) n_state = M_RUN;
        end
    endtask

    // One clock: evaluate the model on settled inputs, clock, then retire the pop.
    task automatic cycle();
        bit pre_pop;
        #1;
        model_eval();
        pre_pop = fifo_tready && fifo_tvalid;
        @(posedge clk);
        #1;
        m_state = n_state;
        exp_state = n_state[1:0]; exp_ov = n_ov; exp_i = n_i; exp_q = n_q; exp_fl = n_fl;
        exp_cnt = m_cnt[15:0];
        if (pre_pop) begin
            void'(fq.pop_front());
            pops++;
        end
        if (out_valid) ov_cnt++;
        refresh();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic tx, input logic stb);
        tx_enable = tx;
        sample_strobe = stb;
        cycle();
    endtask

    always begin
        @(negedge clk);
        if (chk_en) begin
            chk("state", {30'd0, state}, {30'd0, exp_state});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            chk("underrun_count", {16'd0, underrun_count}, {16'd0, exp_cnt});
            if (exp_ov) begin
                chk("i_out", {16'd0, i_out}, {16'd0, exp_i});
                chk("q_out", {16'd0, q_out}, {16'd0, exp_q});
                chk("frame_last", {31'd0, frame_last}, {31'd0, exp_fl});
            end
        end
        #4;
        if (chk_en) chk("fifo_tready", {31'd0, fifo_tready}, {31'd0, exp_tready});
    end

    logic [15:0] lit_i [4];
    logic        lit_fl [4];

    initial begin
        rst = 1'b1; tx_enable = 1'b0; sample_strobe = 1'b0; fifo_tlength = 11'd0;
        refresh();
        @(negedge clk); #1;
        cycle();
        chk_en = 1'b1;

        // Reset with a word waiting: no pop while rst is high.
        push(16'hAAAA, 16'h5555, 1'b0);
        drive(1'b1, 1'b1);
        chk("reset_state", {30'd0, state}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_i_out", {16'd0, i_out}, 32'd0);
        chk("reset_count", {16'd0, underrun_count}, 32'd0);
        chk("reset_no_pop", pops, 32'd0);

        // IDLE drains the leftover word.
        rst = 1'b0;
        drive(1'b0, 1'b0);
        chk("idle_drain_one", pops, 32'd1);

        // PREFILL below threshold: 50 zero strobes, no pops.
        pops = 0; ov_cnt = 0; fifo_tlength = 11'd100;
        for (int k = 0; k < 50; k++) begin
            drive(1'b1, 1'b1);
            drive(1'b1, 1'b0);
        end
        chk("prefill_ov_pulses", ov_cnt, 32'd50);
        chk("prefill_pops", pops, 32'd0);
        chk("prefill_state", {30'd0, state}, 32'd1);

        // Threshold reached with a coincident strobe (zero), then the first real sample.
        push(16'h1234, 16'h5678, 1'b0);
        fifo_tlength = 11'd256;
        drive(1'b1, 1'b1);
        chk("coincident_zero_i", {16'd0, i_out}, 32'd0);
        chk("coincident_no_pop", pops, 32'd0);
        drive(1'b1, 1'b1);
        chk("first_i", {16'd0, i_out}, 32'h1234);
        chk("first_q", {16'd0, q_out}, 32'h5678);
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b1, 1'b0);

        // Three words, four back-to-back strobes: last one underruns.
        push(16'hABCD, 16'hEF01, 1'b0);
        push(16'h8000, 16'h7FFF, 1'b1);
        push(16'hFFFF, 16'h0001, 1'b0);
        fifo_tlength = 11'd3;
        lit_i  = '{16'hABCD, 16'h8000, 16'hFFFF, 16'h0000};
        lit_fl = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1);
            chk("burst_i", {16'd0, i_out}, {16'd0, lit_i[k]});
            chk("burst_frame_last", {31'd0, frame_last}, {31'd0, lit_fl[k]});
        end
        chk("underrun_count_one", {16'd0, underrun_count}, 32'd1);
        chk("underrun_state", {30'd0, state}, 32'd3);
        drive(1'b1, 1'b1);
        fifo_tlength = 11'd255;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        chk("underrun_hold_255", {30'd0, state}, 32'd3);
        fifo_tlength = 11'd256;
        drive(1'b1, 1'b0);
        chk("underrun_recover", {30'd0, state}, 32'd2);

        // tx_enable drop with 10 queued words: no pop that cycle, then drain regardless of strobe.
        for (int k = 0; k < 10; k++) push(16'(k + 1), 16'(k + 100), 1'b0);
        fifo_tlength = 11'd10;
        pops = 0;
        drive(1'b0, 1'b1);
        chk("disable_no_pop", pops, 32'd0);
        chk("disable_idle", {30'd0, state}, 32'd0);
        for (int k = 0; k < 12; k++) drive(1'b0, k[0]);
        chk("drain_pops", pops, 32'd10);

        // Saturation: constant strobes on an empty FIFO with the fill level met.
        fifo_tlength = 11'd256;
        for (int k = 0; k < 131090; k++) drive(1'b1, 1'b1);
        chk("count_saturated", {16'd0, underrun_count}, 32'hFFFF);
        drive(1'b1, 1'b0);
        chk("sat_run", {30'd0, state}, 32'd2);

        // Reset while in RUN with data waiting and a strobe.
        push(16'h0F0F, 16'hF0F0, 1'b1);
        pops = 0;
        rst = 1'b1;
        drive(1'b1, 1'b1);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_count", {16'd0, underrun_count}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_no_pop", pops, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
